// File: rtl/lfsr_checker_pkg.sv
// Shared constants for the 32-bit LFSR stream: state encodings, taps and width.
// The generator uses the same taps, so both ends of the stream stay in step.
package lfsr_checker_pkg;

    localparam int LFSR_W = 32;
    localparam int TAP_A  = 9;
    localparam int TAP_B  = 3;

    typedef enum logic [1:0] {
        ST_SEEK   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

endpackage

// File: rtl/lfsr_checker_next.sv
// Combinational next-state function of the stream LFSR.
// Bit 31 is always zero, which is why a word with bit 31 set cannot be a stream word.
module lfsr_next
    import lfsr_checker_pkg::*;
(
    input  logic [LFSR_W-1:0] cur_i,
    output logic [LFSR_W-1:0] nxt_o
);

    assign nxt_o = {1'b0, cur_i[LFSR_W-3:0], ~(cur_i[TAP_A] ^ cur_i[TAP_B])};

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the LFSR stream: seeds from a received word,
// predicts each following word, declares lock and counts errors while locked.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       data_in,
    input  logic              data_valid,
    input  logic              clear_counts,
    output logic              locked,
    output logic              error_pulse,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count,
    output logic [1:0]        state
);

    state_e             state_q, state_d;
    logic [LFSR_W-1:0]  expected_q, expected_d;
    logic [3:0]         match_q, match_d;
    logic [3:0]         miss_q, miss_d;
    logic               locked_q, locked_d;
    logic               pulse_q, pulse_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   word_q, word_d;
    logic               err_inc, word_inc;
    logic [LFSR_W-1:0]  seed_nxt, pred_nxt;

    lfsr_next u_seed_next (.cur_i(data_in),    .nxt_o(seed_nxt));
    lfsr_next u_pred_next (.cur_i(expected_q), .nxt_o(pred_nxt));

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        match_d    = match_q;
        miss_d     = miss_q;
        pulse_d    = 1'b0;
        err_inc    = 1'b0;
        word_inc   = 1'b0;

        unique case (state_q)
            ST_SEEK: begin
                if (data_valid && !data_in[31]) begin
                    expected_d = seed_nxt;
                    match_d    = '0;
                    state_d    = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (data_valid) begin
                    if (data_in == expected_q) begin
                        match_d    = match_q + 4'd1;
                        expected_d = pred_nxt;
                        if (match_q == 4'(LOCK_COUNT - 1)) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else if (data_in[31]) begin
                        match_d = '0;
                        state_d = ST_SEEK;
                    end else begin
                        // A miss while verifying just means the seed was bad: reseed here.
                        expected_d = seed_nxt;
                        match_d    = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (data_valid) begin
                    expected_d = pred_nxt;
                    word_inc   = 1'b1;
                    if (data_in == expected_q) begin
                        miss_d = '0;
                    end else begin
                        err_inc = 1'b1;
                        pulse_d = 1'b1;
                        miss_d  = miss_q + 4'd1;
                        if (miss_q == 4'(LOSS_COUNT - 1)) begin
                            state_d = ST_SEEK;
                        end
                    end
                end
            end
            default: state_d = ST_SEEK;
        endcase

        locked_d = (state_d == ST_LOCKED);

        // Clear wins over a same-cycle increment; counters saturate at all-ones.
        if (clear_counts) begin
            err_d  = '0;
            word_d = '0;
        end else begin
            err_d  = (err_inc  && err_q  != '1) ? err_q  + 1'b1 : err_q;
            word_d = (word_inc && word_q != '1) ? word_q + 1'b1 : word_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SEEK;
            expected_q <= '0;
            match_q    <= '0;
            miss_q     <= '0;
            locked_q   <= 1'b0;
            pulse_q    <= 1'b0;
            err_q      <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            locked_q   <= locked_d;
            pulse_q    <= pulse_d;
            err_q      <= err_d;
            word_q     <= word_d;
        end
    end

    assign locked      = locked_q;
    assign error_pulse = pulse_q;
    assign err_count   = err_q;
    assign word_count  = word_q;
    assign state       = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, single/burst errors, gaps, reseed,
// clear priority, reset, and counter saturation on a narrow-counter instance.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        data_valid;
    logic        clear_counts;
    logic        locked, error_pulse;
    logic [15:0] err_count, word_count;
    logic [1:0]  state;

    logic [31:0] d2_data;
    logic        d2_valid;
    logic        d2_locked, d2_pulse;
    logic [3:0]  d2_err, d2_word;
    logic [1:0]  d2_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] cur;
    logic [31:0] w;

    always #5 clk = ~clk;

    lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clear_counts(clear_counts), .locked(locked), .error_pulse(error_pulse),
        .err_count(err_count), .word_count(word_count), .state(state)
    );

    lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .data_in(d2_data), .data_valid(d2_valid),
        .clear_counts(1'b0), .locked(d2_locked), .error_pulse(d2_pulse),
        .err_count(d2_err), .word_count(d2_word), .state(d2_state)
    );

    function automatic logic [31:0] nxt(input logic [31:0] v);
        return {1'b0, v[29:0], ~(v[9] ^ v[3])};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle on the main instance; outputs are checked 1 ns after the edge.
    task automatic step(input logic [31:0] word, input logic v, input logic clr, input logic rst);
        @(negedge clk);
        data_in      = word;
        data_valid   = v;
        clear_counts = clr;
        reset        = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic [31:0] word, input logic v);
        @(negedge clk);
        d2_data  = word;
        d2_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send_clean();
        step(cur, 1'b1, 1'b0, 1'b0);
        cur = nxt(cur);
    endtask

    task automatic send_bad();
        step(cur ^ 32'h0000_0020, 1'b1, 1'b0, 1'b0);
        cur = nxt(cur);
    endtask

    initial begin
        data_in = '0; data_valid = 1'b0; clear_counts = 1'b0; reset = 1'b1;
        d2_data = '0; d2_valid = 1'b0;
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);

        check("rst_state",  {30'd0, state}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_pulse",  {31'd0, error_pulse}, 32'd0);
        check("rst_err",    {16'd0, err_count}, 32'd0);
        check("rst_word",   {16'd0, word_count}, 32'd0);

        // Illegal words keep the checker in SEEK.
        step(32'h8000_0001, 1'b1, 1'b0, 1'b0);
        step(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        check("seek_bit31", {30'd0, state}, 32'd0);

        // Clean stream 1, 3, 7, F, 1E: locked after the 5th word.
        cur = 32'h0000_0001;
        for (int i = 0; i < 4; i++) send_clean();
        check("pre_lock_state",  {30'd0, state}, 32'd1);
        check("pre_lock_locked", {31'd0, locked}, 32'd0);
        check("fifth_word",      cur, 32'h0000_001E);
        send_clean();
        check("lock_rise",  {31'd0, locked}, 32'd1);
        check("lock_state", {30'd0, state}, 32'd2);
        check("lock_err",   {16'd0, err_count}, 32'd0);
        check("lock_word",  {16'd0, word_count}, 32'd0);

        send_clean();
        send_clean();
        check("clean_word2", {16'd0, word_count}, 32'd2);

        // Single flipped bit: exactly one error, lock held.
        send_bad();
        check("single_pulse",  {31'd0, error_pulse}, 32'd1);
        check("single_err",    {16'd0, err_count}, 32'd1);
        check("single_locked", {31'd0, locked}, 32'd1);
        send_clean();
        check("after_single_pulse", {31'd0, error_pulse}, 32'd0);
        check("after_single_err",   {16'd0, err_count}, 32'd1);
        check("after_single_word",  {16'd0, word_count}, 32'd4);

        // Invalid cycles with garbage data change nothing.
        step(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        check("gap_pulse", {31'd0, error_pulse}, 32'd0);
        check("gap_err",   {16'd0, err_count}, 32'd1);
        check("gap_word",  {16'd0, word_count}, 32'd4);
        send_clean();
        check("gap_resume_word", {16'd0, word_count}, 32'd5);

        // Three consecutive misses drop lock; counters retained.
        send_bad();
        send_bad();
        check("burst2_locked", {31'd0, locked}, 32'd1);
        send_bad();
        check("burst3_locked", {31'd0, locked}, 32'd0);
        check("burst3_state",  {30'd0, state}, 32'd0);
        check("burst3_err",    {16'd0, err_count}, 32'd4);
        check("burst3_word",   {16'd0, word_count}, 32'd8);

        // Relock with interleaved gaps: 1 seed + 4 matches of valid samples.
        for (int i = 0; i < 4; i++) begin
            send_clean();
            step(32'h1234_5678, 1'b0, 1'b0, 1'b0);
        end
        check("relock_pre_state", {30'd0, state}, 32'd1);
        check("relock_pre_locked", {31'd0, locked}, 32'd0);
        send_clean();
        check("relock_locked", {31'd0, locked}, 32'd1);
        check("relock_err",    {16'd0, err_count}, 32'd4);

        // Reset while locked abandons everything at that edge.
        step(cur, 1'b1, 1'b0, 1'b1);
        check("midrst_state",  {30'd0, state}, 32'd0);
        check("midrst_locked", {31'd0, locked}, 32'd0);
        check("midrst_err",    {16'd0, err_count}, 32'd0);
        check("midrst_word",   {16'd0, word_count}, 32'd0);

        // Mismatch in VERIFY reseeds from that word without counting an error.
        cur = 32'h0000_0055;
        send_clean();
        send_clean();
        w = 32'h0000_1234;
        step(w, 1'b1, 1'b0, 1'b0);
        check("verify_miss_state", {30'd0, state}, 32'd1);
        check("verify_miss_err",   {16'd0, err_count}, 32'd0);
        cur = nxt(w);
        for (int i = 0; i < 3; i++) send_clean();
        check("reseed_pre_locked", {31'd0, locked}, 32'd0);
        send_clean();
        check("reseed_locked", {31'd0, locked}, 32'd1);

        // Bit 31 seen in VERIFY returns to SEEK.
        step('0, 1'b0, 1'b0, 1'b1);
        step(32'h0000_0005, 1'b1, 1'b0, 1'b0);
        check("verify_entry", {30'd0, state}, 32'd1);
        step(32'h8000_0005, 1'b1, 1'b0, 1'b0);
        check("verify_bit31_seek", {30'd0, state}, 32'd0);

        // clear_counts beats a same-cycle error; the pulse still fires.
        cur = 32'h0000_0001;
        for (int i = 0; i < 5; i++) send_clean();
        send_bad();
        check("pre_clear_err", {16'd0, err_count}, 32'd1);
        step(cur ^ 32'h0000_0020, 1'b1, 1'b1, 1'b0);
        cur = nxt(cur);
        check("clear_err",   {16'd0, err_count}, 32'd0);
        check("clear_word",  {16'd0, word_count}, 32'd0);
        check("clear_pulse", {31'd0, error_pulse}, 32'd1);
        send_clean();
        check("post_clear_word", {16'd0, word_count}, 32'd1);
        check("post_clear_locked", {31'd0, locked}, 32'd1);

        // Saturation on the 4-bit-counter instance with LOSS_COUNT = 15.
        w = 32'h0000_0001;
        for (int i = 0; i < 5; i++) begin
            step2(w, 1'b1);
            w = nxt(w);
        end
        check("sat_locked", {31'd0, d2_locked}, 32'd1);
        for (int i = 0; i < 14; i++) begin
            step2(w ^ 32'h0000_0020, 1'b1);
            w = nxt(w);
        end
        check("sat_err14",    {28'd0, d2_err}, 32'd14);
        check("sat_locked14", {31'd0, d2_locked}, 32'd1);
        step2(w, 1'b1);
        w = nxt(w);
        for (int i = 0; i < 14; i++) begin
            step2(w ^ 32'h0000_0020, 1'b1);
            w = nxt(w);
        end
        check("sat_err_hold",  {28'd0, d2_err}, 32'h0000_000F);
        check("sat_word_hold", {28'd0, d2_word}, 32'h0000_000F);
        check("sat_pulse",     {31'd0, d2_pulse}, 32'd1);
        check("sat_still_locked", {31'd0, d2_locked}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
